// File: rtl/spi_regs_pkg.sv
// rtl/spi_regs_pkg.sv - register map, bit indices and FSM states for spi_regs_mc
package spi_regs_pkg;

   localparam logic [31:0] A_CTRL   = 32'd0;
   localparam logic [31:0] A_TIMING = 32'd1;
   localparam logic [31:0] A_TXDATA = 32'd2;
   localparam logic [31:0] A_RXDATA = 32'd3;
   localparam logic [31:0] A_STATUS = 32'd4;

   localparam int CTRL_START  = 0;
   localparam int STATUS_BUSY = 0;
   localparam int STATUS_DONE = 1;
   localparam int STATUS_ERR  = 2;

   // Packed to line up with CTRL[11:1]
   typedef struct packed {
      logic       irq_en;
      logic [3:0] cs_sel;
      logic [1:0] word_len;
      logic [1:0] sck_speed;
      logic [1:0] spi_mode;
   } ctrl_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_RUN,
      ST_CAPT
   } state_t;

endpackage

// File: rtl/SPI_master.sv
// rtl/SPI_master.sv - SPI master core: CS/SCK delays, MSB-first shift, inter-frame gap
module SPI_master (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  spi_mode,
   input  logic [1:0]  sck_speed,
   input  logic [1:0]  word_len,
   input  logic [7:0]  ifg,
   input  logic [7:0]  cs_sck,
   input  logic [7:0]  sck_cs,
   input  logic [31:0] mosi_data,
   input  logic        miso,
   output logic        busy,
   output logic [31:0] miso_data,
   output logic        mosi,
   output logic        sclk,
   output logic        cs_n
);

   typedef enum logic [2:0] {C_IDLE, C_CSSCK, C_XFER, C_SCKCS, C_IFG} cstate_t;

   cstate_t     st_q, st_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  div_q, div_d;
   logic [5:0]  edge_q, edge_d;
   logic [31:0] tx_q, tx_d;
   logic [31:0] rx_q, rx_d;
   logic        sclk_q, sclk_d;
   logic        mosi_q, mosi_d;
   logic        cs_n_q, cs_n_d;

   logic [7:0]  half_m1;
   logic [5:0]  nbits;
   logic [5:0]  last_edge;
   logic [31:0] tx_aligned;
   logic        cpha;

   always_comb begin
      cpha    = spi_mode[0];
      half_m1 = 8'((32'd1 << sck_speed) - 32'd1);
      case (word_len)
         2'd1:    nbits = 6'd8;
         2'd2:    nbits = 6'd16;
         2'd3:    nbits = 6'd24;
         default: nbits = 6'd32;
      endcase
      last_edge  = 6'((32'(nbits) << 1) - 32'd1);
      // Left-align short words so the MSB always leaves from bit 31
      tx_aligned = mosi_data << (32 - 32'(nbits));

      st_d   = st_q;
      cnt_d  = cnt_q;
      div_d  = div_q;
      edge_d = edge_q;
      tx_d   = tx_q;
      rx_d   = rx_q;
      sclk_d = sclk_q;
      mosi_d = mosi_q;
      cs_n_d = cs_n_q;

      case (st_q)
         C_IDLE: begin
            if (start) begin
               st_d   = C_CSSCK;
               cnt_d  = cs_sck;
               cs_n_d = 1'b0;
               rx_d   = '0;
               edge_d = '0;
               sclk_d = 1'b0;
               if (cpha) begin
                  tx_d = tx_aligned;
               end else begin
                  mosi_d = tx_aligned[31];
                  tx_d   = tx_aligned << 1;
               end
            end
         end
         C_CSSCK: begin
            if (cnt_q == 8'd0) begin
               st_d  = C_XFER;
               div_d = half_m1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         C_XFER: begin
            if (div_q == 8'd0) begin
               div_d  = half_m1;
               sclk_d = ~sclk_q;
               edge_d = edge_q + 6'd1;
               // Even edges lead; CPHA decides whether leading edges sample or shift
               if (~edge_q[0] ^ cpha) begin
                  rx_d = {rx_q[30:0], miso};
               end else begin
                  mosi_d = tx_q[31];
                  tx_d   = tx_q << 1;
               end
               if (edge_q == last_edge) begin
                  st_d  = C_SCKCS;
                  cnt_d = sck_cs;
               end
            end else begin
               div_d = div_q - 8'd1;
            end
         end
         C_SCKCS: begin
            if (cnt_q == 8'd0) begin
               st_d   = C_IFG;
               cnt_d  = ifg;
               cs_n_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         C_IFG: begin
            if (cnt_q == 8'd0) st_d = C_IDLE;
            else               cnt_d = cnt_q - 8'd1;
         end
         default: st_d = C_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= C_IDLE;
         cnt_q  <= '0;
         div_q  <= '0;
         edge_q <= '0;
         tx_q   <= '0;
         rx_q   <= '0;
         sclk_q <= 1'b0;
         mosi_q <= 1'b0;
         cs_n_q <= 1'b1;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         edge_q <= edge_d;
         tx_q   <= tx_d;
         rx_q   <= rx_d;
         sclk_q <= sclk_d;
         mosi_q <= mosi_d;
         cs_n_q <= cs_n_d;
      end
   end

   assign busy      = (st_q != C_IDLE);
   assign miso_data = rx_q;
   assign mosi      = mosi_q;
   assign sclk      = sclk_q ^ spi_mode[1];
   assign cs_n      = cs_n_q;

endmodule

// File: rtl/spi_regs_mc.sv
// rtl/spi_regs_mc.sv - register front-end with shadowed config for SPI_master; irq_o with SPI_REGS_MC_IRQ_EN
import spi_regs_pkg::*;

module spi_regs_mc #(
   parameter int NUM_CS = 4,
   parameter int ADDR_W = 3
) (
   input  logic              GCLK,
   input  logic              RST,
   input  logic              wr_en_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              rvalid_o,
   output logic              busy_o,
   input  logic              MISO_i,
   output logic              MOSI_o,
   output logic              SCLK_o,
   output logic [NUM_CS-1:0] CS_o
`ifdef SPI_REGS_MC_IRQ_EN
   ,
   output logic              irq_o
`endif
);

   localparam logic [4:0] NUM_CS_L = 5'(NUM_CS);

   state_t      state_q, state_d;
   ctrl_t       ctrl_q, ctrl_d;
   logic [23:0] timing_q, timing_d;
   logic [31:0] txdata_q, txdata_d;
   logic [31:0] rxdata_q, rxdata_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [1:0]  sh_mode_q, sh_mode_d;
   logic [1:0]  sh_speed_q, sh_speed_d;
   logic [1:0]  sh_len_q, sh_len_d;
   logic [3:0]  sh_cs_q, sh_cs_d;
   logic [23:0] sh_timing_q, sh_timing_d;
   logic [31:0] sh_tx_q, sh_tx_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q, rvalid_d;

   logic [31:0] addr_ext;
   ctrl_t       wr_ctrl;
   logic        busy, wr_cfg, start_req, start_ok, err_set;
   logic        core_start, core_busy, core_cs_n;
   logic [31:0] core_rx;

   always_comb begin
      addr_ext = 32'(addr_i);
      wr_ctrl  = ctrl_t'(wdata_i[11:1]);
`ifndef SPI_REGS_MC_IRQ_EN
      wr_ctrl.irq_en = 1'b0;
`endif
      busy       = (state_q != ST_IDLE);
      core_start = (state_q == ST_LAUNCH);
      wr_cfg     = wr_en_i && (addr_ext == A_CTRL || addr_ext == A_TIMING || addr_ext == A_TXDATA);
      start_req  = wr_en_i && (addr_ext == A_CTRL) && wdata_i[CTRL_START];
      start_ok   = start_req && !busy && ({1'b0, wr_ctrl.cs_sel} < NUM_CS_L);
      err_set    = 1'b0;

      state_d     = state_q;
      ctrl_d      = ctrl_q;
      timing_d    = timing_q;
      txdata_d    = txdata_q;
      rxdata_d    = rxdata_q;
      done_d      = done_q;
      err_d       = err_q;
      sh_mode_d   = sh_mode_q;
      sh_speed_d  = sh_speed_q;
      sh_len_d    = sh_len_q;
      sh_cs_d     = sh_cs_q;
      sh_timing_d = sh_timing_q;
      sh_tx_d     = sh_tx_q;
      rdata_d     = rdata_q;
      rvalid_d    = rd_en_i;

      if (wr_cfg && busy) begin
         err_set = 1'b1;
      end else if (wr_en_i) begin
         if (addr_ext == A_CTRL)   ctrl_d   = wr_ctrl;
         if (addr_ext == A_TIMING) timing_d = wdata_i[23:0];
         if (addr_ext == A_TXDATA) txdata_d = wdata_i;
      end
      if (start_req && !busy && !start_ok) err_set = 1'b1;

      // Shadows take the CTRL fields from the same write that carries START
      if (start_ok) begin
         sh_mode_d   = wr_ctrl.spi_mode;
         sh_speed_d  = wr_ctrl.sck_speed;
         sh_len_d    = wr_ctrl.word_len;
         sh_cs_d     = wr_ctrl.cs_sel;
         sh_timing_d = timing_q;
         sh_tx_d     = txdata_q;
      end

      if (wr_en_i && addr_ext == A_STATUS) begin
         if (wdata_i[STATUS_DONE]) done_d = 1'b0;
         if (wdata_i[STATUS_ERR])  err_d  = 1'b0;
      end

      case (state_q)
         ST_IDLE:   if (start_ok) state_d = ST_LAUNCH;
         ST_LAUNCH: state_d = ST_WAIT;
         ST_WAIT:   if (core_busy) state_d = ST_RUN;
         ST_RUN:    if (!core_busy) state_d = ST_CAPT;
         ST_CAPT: begin
            rxdata_d = core_rx;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
         end
         default:   state_d = ST_IDLE;
      endcase

      // Sets are applied after clears so they win on collision
      if (err_set) err_d = 1'b1;

      if (rd_en_i) begin
         case (addr_ext)
            A_CTRL:   rdata_d = {20'd0, ctrl_q, 1'b0};
            A_TIMING: rdata_d = {8'd0, timing_q};
            A_TXDATA: rdata_d = txdata_q;
            A_RXDATA: rdata_d = rxdata_q;
            A_STATUS: rdata_d = {29'd0, err_q, done_q, busy};
            default:  rdata_d = '0;
         endcase
      end
   end

`ifdef SPI_REGS_MC_IRQ_EN
   logic irq_q, irq_d;
   always_comb irq_d = done_q & ctrl_q.irq_en;
   always_ff @(posedge GCLK) begin
      if (RST) irq_q <= 1'b0;
      else     irq_q <= irq_d;
   end
   assign irq_o = irq_q;
`endif

   always_ff @(posedge GCLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         ctrl_q      <= '0;
         timing_q    <= '0;
         txdata_q    <= '0;
         rxdata_q    <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         sh_mode_q   <= '0;
         sh_speed_q  <= '0;
         sh_len_q    <= '0;
         sh_cs_q     <= '0;
         sh_timing_q <= '0;
         sh_tx_q     <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctrl_q      <= ctrl_d;
         timing_q    <= timing_d;
         txdata_q    <= txdata_d;
         rxdata_q    <= rxdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
         sh_mode_q   <= sh_mode_d;
         sh_speed_q  <= sh_speed_d;
         sh_len_q    <= sh_len_d;
         sh_cs_q     <= sh_cs_d;
         sh_timing_q <= sh_timing_d;
         sh_tx_q     <= sh_tx_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
      end
   end

   SPI_master u_core (
      .clk       (GCLK),
      .rst       (RST),
      .start     (core_start),
      .spi_mode  (sh_mode_q),
      .sck_speed (sh_speed_q),
      .word_len  (sh_len_q),
      .ifg       (sh_timing_q[7:0]),
      .cs_sck    (sh_timing_q[15:8]),
      .sck_cs    (sh_timing_q[23:16]),
      .mosi_data (sh_tx_q),
      .miso      (MISO_i),
      .busy      (core_busy),
      .miso_data (core_rx),
      .mosi      (MOSI_o),
      .sclk      (SCLK_o),
      .cs_n      (core_cs_n)
   );

   always_comb begin
      for (int i = 0; i < NUM_CS; i++) begin
         CS_o[i] = (sh_cs_q == 4'(i)) ? core_cs_n : 1'b1;
      end
   end

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign busy_o   = busy;

endmodule

// File: doc/spi_regs_mc.md
# spi_regs_mc

Register-mapped control front-end for the SPI master core. It gives a host a simple single-cycle register bus with shadowed configuration, one-shot start and sticky status. It also fans the core's single chip select out to `NUM_CS` slave lines. It sits between the host-side bus bridge and the SPI pins, and supersedes the flat per-cycle input registering used so far.

## Interface
Parameters:
- `NUM_CS`, default 4: number of slave chip-select lines (1..16).
- `ADDR_W`, default 3: register address width.

Ports:
- `GCLK`  in  1: system clock.
- `RST`  in  1: synchronous, active-high reset.
- `wr_en_i`  in  1: register write strobe.
- `rd_en_i`  in  1: register read strobe.
- `addr_i`  in  `ADDR_W`: register address.
- `wdata_i`  in  32: write data.
- `rdata_o`  out  32: read data, registered.
- `rvalid_o`  out  1: read data valid, one-cycle pulse.
- `busy_o`  out  1: transfer in progress.
- `MISO_i`  in  1: serial in.
- `MOSI_o`  out  1: serial out.
- `SCLK_o`  out  1: serial clock.
- `CS_o`  out  `NUM_CS`: chip selects, active low.
- `irq_o`  out  1: interrupt, present only with `SPI_REGS_MC_IRQ_EN`.

## Operation
Register map (word addresses):
- 0 CTRL:
  - [0] START, write-1, reads 0.
  - [2:1] spi_mode.
  - [4:3] sck_speed.
  - [6:5] word_len.
  - [10:7] cs_sel.
  - [11] irq_en.
- 1 TIMING: [7:0] IFG, [15:8] CS_SCK, [23:16] SCK_CS.
- 2 TXDATA: read/write.
- 3 RXDATA: read-only.
- 4 STATUS:
  - [0] busy, read-only.
  - [1] done, sticky, write-1-to-clear.
  - [2] err, sticky, write-1-to-clear.
- Other addresses: read 0, writes ignored.

Behaviour:
- Reads and writes in the same cycle are both honoured.
- While busy, writes to CTRL, TIMING and TXDATA are dropped and set err.
  - This includes START.
  - STATUS writes are always accepted.
- START=1 while idle copies CTRL, TIMING and TXDATA into shadow registers. The SPI core sees only shadow values.
- cs_sel ≥ `NUM_CS`: START is rejected, err is set, no transfer runs.
- Chip-select routing: the core's CS drives `CS_o[cs_sel_shadow]`; all other lines are held 1.

FSM states:
- IDLE: START accepted → LAUNCH.
- LAUNCH: pulse core start for one cycle → WAIT.
- WAIT: core busy=1 → RUN.
- RUN: core busy=0 → CAPT.
- CAPT: RXDATA ← core miso_data; done ← 1 → IDLE.

Status and interrupt:
- `busy_o` = (state ≠ IDLE).
- Clearing done while a new transfer runs has no effect on that transfer.
- If a done-set and a done-clear land in the same cycle, the set wins.

## Timing
- Reset values:
  - `rdata_o`=0, `rvalid_o`=0, `busy_o`=0, `MOSI_o`=0, `SCLK_o`=0.
  - `CS_o`=all 1s, `irq_o`=0.
  - All registers and shadows 0; FSM in IDLE.
- Reset mid-transfer: the FSM and core return to reset within 1 cycle, `CS_o` goes all 1s, and no done is set.
- Read latency: `rdata_o` and `rvalid_o` valid the cycle after `rd_en_i`.
- START write at edge t:
  - LAUNCH at t+1; `busy_o`=1 from t+1.
  - Core start high for exactly one cycle, t+1.
- End of transfer: the core's busy fall is seen at edge u. CAPT runs at u+1; RXDATA and done are visible at u+2, where `busy_o`=0.
- Back-to-back: a START accepted in the cycle `busy_o` drops begins the next transfer. The minimum START-to-START gap is therefore transfer length + 3 cycles.

## Configuration
- `SPI_REGS_MC_IRQ_EN` defined:
  - `irq_o` port exists.
  - `irq_o` = done & irq_en, registered, so one cycle behind the status bit.
  - CTRL[11] is read/write.
- Not defined:
  - No `irq_o` port.
  - CTRL[11] reads 0 and ignores writes.

## Structure
- Package `spi_regs_pkg`:
  - Register address constants (CTRL, TIMING, TXDATA, RXDATA, STATUS).
  - CTRL and STATUS bit-index constants.
  - FSM state enum (IDLE, LAUNCH, WAIT, RUN, CAPT).
- Sub-module: the existing `SPI_master` core, instantiated once, with all its inputs driven from the shadow registers.
- Chip-select decode is inline logic, not a separate module.

## Test plan
- Reset, then read every address → all return 0. `CS_o`=4'b1111.
- Write TXDATA=0xA5A5_0F0F, TIMING=0x0002_0202, CTRL=START|cs_sel=2, mode 0, 32-bit, with MISO looped to MOSI:
  - `CS_o`=4'b1011 during the transfer.
  - RXDATA=0xA5A5_0F0F afterwards.
  - STATUS=0x2.
- Write TXDATA=0x1234 while busy → STATUS.err=1; the transfer still completes with the original shadow data.
- CTRL with START and cs_sel=5 (`NUM_CS`=4) → no SCLK activity, err=1, busy stays 0.
- Assert `RST` mid-transfer → next cycle `CS_o`=all 1s, `busy_o`=0, done=0.
- With IRQ_EN and irq_en=1, complete a transfer → `irq_o` rises one cycle after done. Writing STATUS=0x2 clears both done and `irq_o`.
